// File: rtl/seq_tx_gen.sv
// Serial pattern transmitter: sends a latched pattern MSB-first, repeated F times
// with an optional idle gap between frames, then pulses o_done.
//
// state | meaning
// IDLE  | waiting for i_start; also the o_done cycle
// SEND  | shifting pattern bits onto o_x, o_valid=1
// GAP   | inter-frame idle, o_busy=1, o_valid=0

module seq_tx_gen #(
    parameter int P_WIDTH = 4,
    parameter int P_RPT_W = 4,
    parameter int P_GAP_W = 4
) (
    input  logic               i_clk,
    input  logic               i_rst_b,
    input  logic               i_start,
    input  logic               i_abort,
    input  logic [P_WIDTH-1:0] i_pattern,
    input  logic [P_RPT_W-1:0] i_repeat,
    input  logic [P_GAP_W-1:0] i_gap,
    output logic               o_x,
    output logic               o_valid,
    output logic               o_busy,
    output logic               o_done
);

    localparam int CNT_W = (P_WIDTH > 2) ? $clog2(P_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(P_WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_SEND = 2'b01,
        ST_GAP  = 2'b10
    } state_t;

    state_t             state_q;
    logic [P_WIDTH-1:0] pat_q;
    logic [P_WIDTH-1:0] sh_q;
    logic [P_RPT_W-1:0] rpt_q;
    logic [P_RPT_W-1:0] frm_q;
    logic [P_GAP_W-1:0] gap_q;
    logic [P_GAP_W-1:0] gcnt_q;
    logic [CNT_W-1:0]   bit_q;
    logic               x_q;
    logic               valid_q;
    logic               busy_q;
    logic               done_q;

    assign o_x     = x_q;
    assign o_valid = valid_q;
    assign o_busy  = busy_q;
    assign o_done  = done_q;

    // sh_q holds the bits still to be sent; the MSB goes straight to x_q on load
    // so the first bit appears in the cycle right after the accepting edge.
    always_ff @(posedge i_clk or negedge i_rst_b) begin
        if (!i_rst_b) begin
            state_q <= ST_IDLE;
            pat_q   <= '0;
            sh_q    <= '0;
            rpt_q   <= '0;
            frm_q   <= '0;
            gap_q   <= '0;
            gcnt_q  <= '0;
            bit_q   <= '0;
            x_q     <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (i_abort) begin
                state_q <= ST_IDLE;
                x_q     <= 1'b0;
                valid_q <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (i_start) begin
                            state_q <= ST_SEND;
                            pat_q   <= i_pattern;
                            rpt_q   <= i_repeat;
                            gap_q   <= i_gap;
                            sh_q    <= {i_pattern[P_WIDTH-2:0], 1'b0};
                            bit_q   <= '0;
                            frm_q   <= '0;
                            x_q     <= i_pattern[P_WIDTH-1];
                            valid_q <= 1'b1;
                            busy_q  <= 1'b1;
                        end else begin
                            x_q     <= 1'b0;
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                        end
                    end
                    ST_SEND: begin
                        if (bit_q != LAST_BIT) begin
                            x_q   <= sh_q[P_WIDTH-1];
                            sh_q  <= {sh_q[P_WIDTH-2:0], 1'b0};
                            bit_q <= bit_q + 1'b1;
                        end else if (frm_q == rpt_q) begin
                            state_q <= ST_IDLE;
                            x_q     <= 1'b0;
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            frm_q <= frm_q + 1'b1;
                            bit_q <= '0;
                            if (gap_q == '0) begin
                                x_q  <= pat_q[P_WIDTH-1];
                                sh_q <= {pat_q[P_WIDTH-2:0], 1'b0};
                            end else begin
                                state_q <= ST_GAP;
                                gcnt_q  <= gap_q - 1'b1;
                                x_q     <= 1'b0;
                                valid_q <= 1'b0;
                            end
                        end
                    end
                    ST_GAP: begin
                        if (gcnt_q == '0) begin
                            state_q <= ST_SEND;
                            x_q     <= pat_q[P_WIDTH-1];
                            sh_q    <= {pat_q[P_WIDTH-2:0], 1'b0};
                            valid_q <= 1'b1;
                        end else begin
                            gcnt_q <= gcnt_q - 1'b1;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        x_q     <= 1'b0;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_seq_tx_gen.sv
// Bench for seq_tx_gen: per-cycle expected {x,valid,busy,done} tuples are queued
// when a transfer is started and popped/compared as the DUT produces each cycle.

module tb_seq_tx_gen;

    logic       clk = 1'b0;
    logic       rst_b;
    logic       start;
    logic       abort;
    logic [3:0] pattern;
    logic [3:0] rpt;
    logic [3:0] gap;
    logic       o_x;
    logic       o_valid;
    logic       o_busy;
    logic       o_done;

    int         n_checks = 0;
    int         n_fail = 0;
    logic [3:0] exp_q[$];
    int         busy_seen;
    int         det_hits;
    logic [3:0] det_sh;

    always #5 clk = ~clk;

    seq_tx_gen #(.P_WIDTH(4), .P_RPT_W(4), .P_GAP_W(4)) dut (
        .i_clk     (clk),
        .i_rst_b   (rst_b),
        .i_start   (start),
        .i_abort   (abort),
        .i_pattern (pattern),
        .i_repeat  (rpt),
        .i_gap     (gap),
        .o_x       (o_x),
        .o_valid   (o_valid),
        .o_busy    (o_busy),
        .o_done    (o_done)
    );

    task automatic push_frames(input logic [3:0] p, input logic [3:0] r,
                               input logic [3:0] g, input bit tail);
        for (int f = 0; f <= int'(r); f++) begin
            for (int j = 0; j < 4; j++) exp_q.push_back({p[3-j], 1'b1, 1'b1, 1'b0});
            if (f < int'(r))
                for (int k = 0; k < int'(g); k++) exp_q.push_back(4'b0010);
        end
        exp_q.push_back(4'b0001);
        if (tail) exp_q.push_back(4'b0000);
    endtask

    task automatic start_xfer(input logic [3:0] p, input logic [3:0] r,
                              input logic [3:0] g, input bit tail);
        @(negedge clk);
        pattern = p;
        rpt     = r;
        gap     = g;
        start   = 1'b1;
        busy_seen = 0;
        det_hits  = 0;
        det_sh    = 4'b0000;
        push_frames(p, r, g, tail);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // inj_kind: 0 none, 1 start with new inputs, 2 abort; driven during cycle inj_at
    task automatic run_check(input string name, input int n, input int inj_at,
                             input int inj_kind, input logic [3:0] ip,
                             input logic [3:0] ir, input logic [3:0] ig);
        for (int k = 0; k < n; k++) begin
            logic [3:0] e;
            logic [3:0] a;
            a = {o_x, o_valid, o_busy, o_done};
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL %s cycle %0d: got %b, scoreboard empty", name, k, a);
            end else begin
                e = exp_q.pop_front();
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL %s cycle %0d: {x,valid,busy,done} got %b expected %b",
                             name, k, a, e);
                end
            end
            if (o_busy) busy_seen++;
            if (o_valid) begin
                det_sh = {det_sh[2:0], o_x};
                if (det_sh == 4'b1001) det_hits++;
            end
            if (k == inj_at) begin
                if (inj_kind == 1) begin
                    start   = 1'b1;
                    pattern = ip;
                    rpt     = ir;
                    gap     = ig;
                end else if (inj_kind == 2) begin
                    abort = 1'b1;
                end
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            abort = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_b = 1'b1;
        #1;
        rst_b = 1'b0;
        #1;
        n_checks++;
        if ({o_x, o_valid, o_busy, o_done} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_async: got %b expected 0000", {o_x, o_valid, o_busy, o_done});
        end
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({o_x, o_valid, o_busy, o_done} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_hold: got %b expected 0000", {o_x, o_valid, o_busy, o_done});
        end
        @(negedge clk);
        rst_b = 1'b1;
        exp_q.delete();
        repeat (2) exp_q.push_back(4'b0000);
        @(posedge clk);
        #1;
        run_check("reset_release", 2, -1, 0, 4'h0, 4'h0, 4'h0);
    endtask

    task automatic test_single();
        start_xfer(4'b1001, 4'd0, 4'd0, 1'b1);
        run_check("single", 6, -1, 0, 4'h0, 4'h0, 4'h0);
        n_checks++;
        if (busy_seen != 4) begin
            n_fail++;
            $display("FAIL single_busy_len: got %0d expected 4", busy_seen);
        end
    endtask

    task automatic test_back_to_back();
        start_xfer(4'b1001, 4'd1, 4'd0, 1'b1);
        run_check("back_to_back", 10, -1, 0, 4'h0, 4'h0, 4'h0);
        n_checks++;
        if (busy_seen != 8) begin
            n_fail++;
            $display("FAIL b2b_busy_len: got %0d expected 8", busy_seen);
        end
        n_checks++;
        if (det_hits != 2) begin
            n_fail++;
            $display("FAIL b2b_detect: got %0d hits expected 2", det_hits);
        end
    endtask

    task automatic test_gap();
        start_xfer(4'b1101, 4'd2, 4'd3, 1'b1);
        run_check("gap", 20, -1, 0, 4'h0, 4'h0, 4'h0);
        n_checks++;
        if (busy_seen != 18) begin
            n_fail++;
            $display("FAIL gap_busy_len: got %0d expected 18", busy_seen);
        end
    endtask

    task automatic test_start_handling();
        start_xfer(4'b1001, 4'd0, 4'd0, 1'b1);
        run_check("start_ignored", 6, 1, 1, 4'b0110, 4'd2, 4'd1);
        n_checks++;
        if (busy_seen != 4) begin
            n_fail++;
            $display("FAIL ignored_busy_len: got %0d expected 4", busy_seen);
        end
        start_xfer(4'b1010, 4'd0, 4'd0, 1'b0);
        push_frames(4'b0011, 4'd0, 4'd0, 1'b1);
        run_check("start_in_done", 11, 4, 1, 4'b0011, 4'd0, 4'd0);
    endtask

    task automatic test_abort();
        start_xfer(4'b1011, 4'd3, 4'd0, 1'b1);
        run_check("abort_pre", 7, 6, 2, 4'h0, 4'h0, 4'h0);
        exp_q.delete();
        repeat (6) exp_q.push_back(4'b0000);
        run_check("abort_post", 6, -1, 0, 4'h0, 4'h0, 4'h0);
        @(negedge clk);
        start   = 1'b1;
        abort   = 1'b1;
        pattern = 4'b1111;
        rpt     = 4'd0;
        gap     = 4'd0;
        repeat (4) exp_q.push_back(4'b0000);
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        run_check("abort_with_start", 4, -1, 0, 4'h0, 4'h0, 4'h0);
    endtask

    task automatic test_async_reset();
        start_xfer(4'b1101, 4'd1, 4'd4, 1'b1);
        run_check("arst_pre", 6, -1, 0, 4'h0, 4'h0, 4'h0);
        #2;
        rst_b = 1'b0;
        #1;
        n_checks++;
        if ({o_x, o_valid, o_busy, o_done} !== 4'b0000) begin
            n_fail++;
            $display("FAIL arst_immediate: got %b expected 0000", {o_x, o_valid, o_busy, o_done});
        end
        @(negedge clk);
        rst_b = 1'b1;
        exp_q.delete();
        repeat (2) exp_q.push_back(4'b0000);
        @(posedge clk);
        #1;
        run_check("arst_idle", 2, -1, 0, 4'h0, 4'h0, 4'h0);
        start_xfer(4'b0110, 4'd0, 4'd0, 1'b1);
        run_check("arst_fresh", 6, -1, 0, 4'h0, 4'h0, 4'h0);
        n_checks++;
        if (busy_seen != 4) begin
            n_fail++;
            $display("FAIL arst_busy_len: got %0d expected 4", busy_seen);
        end
    endtask

    initial begin
        start     = 1'b0;
        abort     = 1'b0;
        pattern   = 4'h0;
        rpt       = 4'h0;
        gap       = 4'h0;
        busy_seen = 0;
        det_hits  = 0;
        det_sh    = 4'b0000;
        test_reset();
        test_single();
        test_back_to_back();
        test_gap();
        test_start_handling();
        test_abort();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/seq_tx_gen.md
Name: seq_tx_gen

Overview:
- Serial pattern transmitter: the sending end of the serial bit-sequence interface consumed by the team's Mealy sequence detectors.
- On a start command it latches a programmable P_WIDTH-bit pattern and shifts it out MSB-first, one bit per clock.
- Repeats the frame a programmable number of times, with an optional idle gap between frames, and pulses done at the end.
- Sits in front of a detector as stimulus source and link driver; o_x connects directly to a detector's i_x.

Parameters:
- P_WIDTH, 4, pattern length in bits (legal range 2..16).
- P_RPT_W, 4, width of the repeat-count input.
- P_GAP_W, 4, width of the inter-frame gap input.

Ports:
- i_clk  input  1  clock, all logic on rising edge
- i_rst_b  input  1  asynchronous active-low reset
- i_start  input  1  start request, sampled only when idle
- i_abort  input  1  synchronous abort, highest priority after reset
- i_pattern  input  P_WIDTH  pattern to send, latched on accepted start
- i_repeat  input  P_RPT_W  extra frames; total frames F = i_repeat+1, latched on start
- i_gap  input  P_GAP_W  idle cycles G between frames, latched on start
- o_x  output  1  serial data bit
- o_valid  output  1  o_x carries a pattern bit this cycle
- o_busy  output  1  transfer in progress, start ignored
- o_done  output  1  one-cycle pulse after the last bit of the last frame

Behaviour:
- Clock and reset: one clock, i_clk. Reset is asynchronous, active-low, on i_rst_b.
- All outputs are registered.
- Reset values: o_x=0, o_valid=0, o_busy=0, o_done=0, state=IDLE. All counters and shift register are cleared.
- States:
  - IDLE: o_busy=0, o_valid=0, o_x=0.
  - SEND: o_busy=1, o_valid=1, o_x=current bit.
  - GAP: o_busy=1, o_valid=0, o_x=0.
- Start acceptance: i_start=1 sampled at edge E0 while in IDLE (or in the o_done cycle, which is IDLE) latches i_pattern, i_repeat and i_gap.
  - Bit j (pattern[P_WIDTH-1-j]) is driven in the cycle after edge E0+j.
  - There is no bubble between start and the first bit.
- Bit counter: runs 0..P_WIDTH-1 within a frame. Frame counter runs 0..F-1.
- End of a frame that is not the last:
  - G>0: enter GAP for exactly G cycles, then SEND the next frame.
  - G=0: the next frame's MSB follows immediately, giving a continuous stream.
- End of the last frame: next edge enters IDLE with o_done=1 for exactly one cycle, o_busy=0, o_valid=0.
- Total cycles with o_busy=1: F*P_WIDTH + (F-1)*G.
- i_start while busy: ignored, not queued. Latched values are unaffected by input changes mid-transfer.
- i_start in the o_done cycle: accepted; next cycle is the new frame's first bit and o_done drops.
- i_abort=1 at any edge: next state IDLE, o_valid=0, o_x=0, o_busy=0, o_done=0. No done pulse is issued.
  - Abort wins over a simultaneous i_start.
- Reset asserted mid-transfer: outputs go to reset values immediately (asynchronously). After release, the block waits in IDLE.
- Illegal/unused state encodings recover to IDLE on the next edge.

Test Plan:
- Reset then single frame: pattern=4'b1001, repeat=0, gap=0, start pulse.
  - o_x over 4 valid cycles = 1,0,0,1.
  - o_done high in cycle 5 only; o_busy high for exactly 4 cycles.
- Back-to-back overlap stream: pattern=4'b1001, repeat=1, gap=0.
  - Valid stream = 10011001 over 8 consecutive cycles.
  - A connected overlap detector flags twice.
- Gap insertion: pattern=4'b1101, repeat=2, gap=3.
  - Valid bits 1101, 3 cycles o_valid=0/o_x=0, 1101, 3 idle cycles, 1101.
  - o_busy high for 18 cycles; one o_done pulse.
- Start handling:
  - Second start mid-transfer is ignored and i_pattern is changed mid-transfer: output unaffected.
  - Start asserted in the o_done cycle: new frame begins on the next cycle with no gap.
- Abort: assert i_abort during bit 2 of frame 1 of a repeat=3 transfer.
  - Next cycle o_valid=0, o_busy=0; no o_done.
  - Abort with simultaneous start stays IDLE.
- Async reset: drop i_rst_b mid-GAP between clock edges.
  - Outputs clear immediately without a clock edge.
  - After release, a fresh start sends a correct full frame.
